// File: rtl/seq_multiplier_sm.sv
// Multi-cycle shift-add multiplier (signed/unsigned) with architectural HI/LO
// registers and a registered MFHI/MFLO/OUT readback port.
module seq_multiplier_sm #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  input  logic [5:0]           Signal,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dataOut
);

  localparam logic [5:0] CMD_MULT  = 6'd24;
  localparam logic [5:0] CMD_MULTU = 6'd25;
  localparam logic [5:0] CMD_MFHI  = 6'd16;
  localparam logic [5:0] CMD_MFLO  = 6'd18;
  localparam logic [5:0] CMD_OUT   = 6'd63;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_count;
  logic [2*WIDTH-1:0]   r_hilo;
  logic [WIDTH-1:0]     r_magb;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_dout;

  logic                 w_is_mul;
  logic                 w_signed;
  logic [WIDTH-1:0]     w_maga;
  logic [WIDTH-1:0]     w_magb;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_hilo_shift;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_is_mul = (Signal == CMD_MULT) || (Signal == CMD_MULTU);
  assign w_signed = (Signal == CMD_MULT);

  // Negating the most negative value wraps to itself, which read as unsigned is
  // exactly its magnitude 2**(WIDTH-1).
  assign w_maga = (w_signed && dataA[WIDTH-1]) ? -dataA : dataA;
  assign w_magb = (w_signed && dataB[WIDTH-1]) ? -dataB : dataB;

  assign w_sum        = {1'b0, r_hilo[2*WIDTH-1:WIDTH]} + (r_hilo[0] ? {1'b0, r_magb} : '0);
  assign w_hilo_shift = {w_sum, r_hilo[WIDTH-1:1]};
  assign w_prod       = r_neg ? -r_hilo : r_hilo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_hilo  <= '0;
      r_magb  <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_is_mul) begin
            r_neg   <= w_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
            r_magb  <= w_magb;
            r_hilo  <= {{WIDTH{1'b0}}, w_maga};
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_hilo  <= w_hilo_shift;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) r_state <= ST_FIN;
        end
        ST_FIN: begin
          {r_hi, r_lo} <= w_prod;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Readback sees HI/LO as they were before this edge.
      case (Signal)
        CMD_OUT:  r_dout <= {r_hi, r_lo};
        CMD_MFHI: r_dout <= {{WIDTH{1'b0}}, r_hi};
        CMD_MFLO: r_dout <= {{WIDTH{1'b0}}, r_lo};
        default:  ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign dataOut = r_dout;

endmodule
